control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 195 +++++++++++++++++++
 tb/tb_control_unit.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle controller: fetch, decode, execute, memory, write-back and halt
// for a small MIPS-like datapath. Every output is decoded from the current
// state and the instruction word, so the datapath sees its controls in the
// same cycle the state is entered.
module control_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR,
   input  logic        Z,
   input  logic        N,
   input  logic        mem_ready,
   output logic        ir_ld,
   output logic        pc_inc,
   output logic        pc_ld,
   output logic        mem_req,
   output logic        mem_wr,
   output logic        D_En,
   output logic [4:0]  D_Addr,
   output logic [4:0]  S_Addr,
   output logic [4:0]  T_Addr,
   output logic [4:0]  FS,
   output logic        HILO_ld,
   output logic        T_Sel,
   output logic [31:0] DT,
   output logic [2:0]  Y_Sel,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_NOP, C_ALU, C_MULT, C_MFHI, C_MFLO, C_ADDI,
      C_LW, C_SW, C_BEQ, C_BNE, C_HALT
   } iclass_t;

   state_t  state_q, state_d;
   logic    rst_q;      // high for the one cycle that follows a reset edge
   iclass_t cls;
   logic [4:0] alu_fs;

   // The status flag N is part of the datapath interface but no supported
   // instruction branches on it.
   logic unused_n;
   assign unused_n = N;

   // The immediate operand is always presented; the datapath picks it with T_Sel.
   assign DT = {{16{IR[15]}}, IR[15:0]};

   // State register; reset also arms a one-cycle output quiet period so that
   // no strobe (including mem_req) is seen in the cycle after a reset edge.
   // NOTE: synchronous reset lives inside the clocked block, and all state
   // updates use non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         rst_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rst_q   <= 1'b0;
      end
   end

   // Instruction classification and ALU function code for R-type arithmetic.
   always_comb begin
      cls    = C_NOP;
      alu_fs = 5'h00;
      case (IR[31:26])
         6'h00: begin
            case (IR[5:0])
               6'h20: begin cls = C_ALU; alu_fs = 5'h02; end
               6'h21: begin cls = C_ALU; alu_fs = 5'h03; end
               6'h22: begin cls = C_ALU; alu_fs = 5'h04; end
               6'h24: begin cls = C_ALU; alu_fs = 5'h08; end
               6'h25: begin cls = C_ALU; alu_fs = 5'h09; end
               6'h2A: begin cls = C_ALU; alu_fs = 5'h06; end
               6'h18: cls = C_MULT;
               6'h10: cls = C_MFHI;
               6'h12: cls = C_MFLO;
               default: cls = C_NOP;
            endcase
         end
         6'h08:   cls = C_ADDI;
         6'h23:   cls = C_LW;
         6'h2B:   cls = C_SW;
         6'h04:   cls = C_BEQ;
         6'h05:   cls = C_BNE;
         6'h3F:   cls = C_HALT;
         default: cls = C_NOP;
      endcase
   end

   // Next-state and output decode.
   // NOTE: every output and state_d gets a default first, so no path through
   // the case statements can leave a value unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      ir_ld   = 1'b0;
      pc_inc  = 1'b0;
      pc_ld   = 1'b0;
      mem_req = 1'b0;
      mem_wr  = 1'b0;
      D_En    = 1'b0;
      D_Addr  = 5'd0;
      S_Addr  = 5'd0;
      T_Addr  = 5'd0;
      FS      = 5'h00;
      HILO_ld = 1'b0;
      T_Sel   = 1'b0;
      Y_Sel   = 3'b010;
      halted  = 1'b0;

      if (!rst_q) begin
         if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            S_Addr = IR[25:21];
            T_Addr = IR[20:16];
         end
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_ld   = 1'b1;
                  pc_inc  = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               case (cls)
                  C_MFHI, C_MFLO: state_d = S_WB;
                  C_HALT:         state_d = S_HALT;
                  C_NOP:          state_d = S_FETCH;
                  default:        state_d = S_EXEC;
               endcase
            end
            S_EXEC: begin
               state_d = S_FETCH;
               case (cls)
                  C_ALU: begin
                     FS      = alu_fs;
                     state_d = S_WB;
                  end
                  C_MULT: begin
                     FS      = 5'h1E;
                     HILO_ld = 1'b1;
                  end
                  C_ADDI: begin
                     FS      = 5'h02;
                     T_Sel   = 1'b1;
                     state_d = S_WB;
                  end
                  C_LW, C_SW: begin
                     FS      = 5'h02;
                     T_Sel   = 1'b1;
                     state_d = S_MEM;
                  end
                  C_BEQ: begin
                     FS    = 5'h04;
                     pc_ld = Z;
                  end
                  C_BNE: begin
                     FS    = 5'h04;
                     pc_ld = ~Z;
                  end
                  default: state_d = S_FETCH;
               endcase
            end
            S_MEM: begin
               mem_req = 1'b1;
               mem_wr  = (cls == C_SW);
               if (mem_ready) state_d = (cls == C_SW) ? S_FETCH : S_WB;
            end
            S_WB: begin
               D_En    = 1'b1;
               state_d = S_FETCH;
               case (cls)
                  C_MFHI: begin Y_Sel = 3'b000; D_Addr = IR[15:11]; end
                  C_MFLO: begin Y_Sel = 3'b001; D_Addr = IR[15:11]; end
                  C_ADDI: D_Addr = IR[20:16];
                  C_LW:   begin Y_Sel = 3'b011; D_Addr = IR[20:16]; end
                  default: D_Addr = IR[15:11];
               endcase
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Randomised and directed bench for control_unit. The reference model turns
// each instruction into the list of per-cycle control vectors it should
// produce (a timeline), then the bench replays it cycle by cycle.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IR;
   logic        Z, N, mem_ready;
   logic        ir_ld, pc_inc, pc_ld, mem_req, mem_wr, D_En;
   logic [4:0]  D_Addr, S_Addr, T_Addr, FS;
   logic        HILO_ld, T_Sel, halted;
   logic [31:0] DT;
   logic [2:0]  Y_Sel;

   control_unit dut (
      .clk(clk), .reset(reset), .IR(IR), .Z(Z), .N(N), .mem_ready(mem_ready),
      .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .mem_req(mem_req),
      .mem_wr(mem_wr), .D_En(D_En), .D_Addr(D_Addr), .S_Addr(S_Addr),
      .T_Addr(T_Addr), .FS(FS), .HILO_ld(HILO_ld), .T_Sel(T_Sel), .DT(DT),
      .Y_Sel(Y_Sel), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ir_ld, pc_inc, pc_ld, mem_req, mem_wr, d_en;
      logic [4:0] d_addr, s_addr, t_addr, fs;
      logic       hilo_ld, t_sel;
      logic [2:0] y_sel;
      logic       halted;
   } outs_t;

   typedef struct {
      outs_t o;
      logic  rdy;
   } step_t;

   outs_t got;
   assign got = {ir_ld, pc_inc, pc_ld, mem_req, mem_wr, D_En, D_Addr, S_Addr,
                 T_Addr, FS, HILO_ld, T_Sel, Y_Sel, halted};

   int          n_tests = 0;
   int          n_fail  = 0;
   step_t       q[$];
   logic [31:0] cur_ir;
   logic        cur_z;
   int          obs_mem_req, obs_d_en, obs_pc_ld, obs_hilo;

   function automatic outs_t idle();
      outs_t o = '0;
      o.y_sel = 3'b010;
      return o;
   endfunction

   function automatic void push(outs_t o, logic rdy);
      step_t s;
      s.o   = o;
      s.rdy = rdy;
      q.push_back(s);
   endfunction

   // Reference timeline for one instruction: fd wait cycles before the fetch
   // completes, md wait cycles in the memory phase, hc cycles observed in HALT.
   function automatic void build(logic [31:0] ir, logic z, int fd, int md, int hc);
      logic [5:0] op = ir[31:26];
      logic [5:0] fn = ir[5:0];
      logic [4:0] rt = ir[20:16];
      logic [4:0] rd = ir[15:11];
      outs_t o, regs;
      logic [4:0] afs;
      logic is_alu = 1'b0;
      for (int i = 0; i < fd; i++) begin
         o = idle(); o.mem_req = 1'b1; push(o, 1'b0);
      end
      o = idle(); o.mem_req = 1'b1; o.ir_ld = 1'b1; o.pc_inc = 1'b1; push(o, 1'b1);
      regs = idle(); regs.s_addr = ir[25:21]; regs.t_addr = rt;
      push(regs, 1'b0);
      afs = 5'h00;
      if (op == 6'h00) begin
         is_alu = 1'b1;
         case (fn)
            6'h20: afs = 5'h02;  6'h21: afs = 5'h03;  6'h22: afs = 5'h04;
            6'h24: afs = 5'h08;  6'h25: afs = 5'h09;  6'h2A: afs = 5'h06;
            default: is_alu = 1'b0;
         endcase
      end
      if (is_alu) begin
         o = regs; o.fs = afs; push(o, 1'b0);
         o = regs; o.d_en = 1'b1; o.d_addr = rd; push(o, 1'b0);
      end else if (op == 6'h00 && fn == 6'h18) begin
         o = regs; o.fs = 5'h1E; o.hilo_ld = 1'b1; push(o, 1'b0);
      end else if (op == 6'h00 && (fn == 6'h10 || fn == 6'h12)) begin
         o = regs; o.d_en = 1'b1; o.d_addr = rd;
         o.y_sel = (fn == 6'h10) ? 3'b000 : 3'b001; push(o, 1'b0);
      end else if (op == 6'h08) begin
         o = regs; o.fs = 5'h02; o.t_sel = 1'b1; push(o, 1'b0);
         o = regs; o.d_en = 1'b1; o.d_addr = rt; push(o, 1'b0);
      end else if (op == 6'h23 || op == 6'h2B) begin
         o = regs; o.fs = 5'h02; o.t_sel = 1'b1; push(o, 1'b0);
         o = regs; o.mem_req = 1'b1; o.mem_wr = (op == 6'h2B);
         for (int i = 0; i < md; i++) push(o, 1'b0);
         push(o, 1'b1);
         if (op == 6'h23) begin
            o = regs; o.d_en = 1'b1; o.d_addr = rt; o.y_sel = 3'b011; push(o, 1'b0);
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         o = regs; o.fs = 5'h04; o.pc_ld = (op == 6'h04) ? z : ~z; push(o, 1'b0);
      end else if (op == 6'h3F) begin
         for (int i = 0; i < hc; i++) begin
            o = idle(); o.halted = 1'b1; push(o, 1'b0);
         end
      end
   endfunction

   // Replays up to n timeline steps, comparing every output once per cycle.
   task automatic play(string name, int n);
      step_t s;
      int k = 0;
      obs_mem_req = 0; obs_d_en = 0; obs_pc_ld = 0; obs_hilo = 0;
      while (q.size() > 0 && k < n) begin
         s = q.pop_front();
         @(negedge clk);
         if (k == 0) IR = cur_ir;
         Z = cur_z;
         N = 1'($urandom_range(0, 1));
         mem_ready = s.o.mem_req ? s.rdy : 1'($urandom_range(0, 1));
         #1;
         n_tests++;
         if (got !== s.o) begin
            n_fail++;
            $display("FAIL %s step %0d ir=%h: outputs got %h expected %h", name, k, cur_ir, got, s.o);
         end
         n_tests++;
         if (DT !== {{16{cur_ir[15]}}, cur_ir[15:0]}) begin
            n_fail++;
            $display("FAIL %s step %0d DT got %h expected %h", name, k, DT, {{16{cur_ir[15]}}, cur_ir[15:0]});
         end
         obs_mem_req += int'(mem_req);
         obs_d_en    += int'(D_En);
         obs_pc_ld   += int'(pc_ld);
         obs_hilo    += int'(HILO_ld);
         k++;
      end
   endtask

   task automatic run(string name, logic [31:0] ir, logic z, int fd, int md);
      cur_ir = ir;
      cur_z  = z;
      build(ir, z, fd, md, 4);
      play(name, 1000);
   endtask

   // Applies a reset pulse and checks the quiet cycle and the first fetch.
   task automatic pulse_reset(string name);
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (got !== idle()) begin
         n_fail++;
         $display("FAIL %s quiet cycle got %h expected %h", name, got, idle());
      end
      reset = 1'b0; mem_ready = 1'b0;
      @(negedge clk); #1;
      n_tests++;
      if (mem_req !== 1'b1 || ir_ld !== 1'b0 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL %s first fetch mem_req=%b ir_ld=%b halted=%b expected 1 0 0", name, mem_req, ir_ld, halted);
      end
   endtask

   task automatic test_reset();
      IR = 32'h0; Z = 1'b0; N = 1'b0; mem_ready = 1'b1; reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_tests++;
         if (got !== idle()) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d got %h expected %h", i, got, idle());
         end
      end
      reset = 1'b0; mem_ready = 1'b0;
      @(negedge clk); #1;
      n_tests++;
      if (mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release mem_req got %b expected 1", mem_req);
      end
   endtask

   task automatic test_add();
      run("add", 32'h012A4020, 1'b0, 0, 0);
      n_tests++;
      if (obs_d_en !== 1) begin
         n_fail++;
         $display("FAIL add_d_en_count got %0d expected 1", obs_d_en);
      end
   endtask

   task automatic test_lw_delay();
      run("lw", 32'h8D0B0004, 1'b0, 0, 3);
      n_tests++;
      if (obs_mem_req !== 5) begin
         n_fail++;
         $display("FAIL lw_mem_req_cycles got %0d expected 5", obs_mem_req);
      end
   endtask

   task automatic test_branch();
      run("beq_taken", 32'h11090003, 1'b1, 0, 0);
      n_tests++;
      if (obs_pc_ld !== 1) begin
         n_fail++;
         $display("FAIL beq_taken_pc_ld got %0d expected 1", obs_pc_ld);
      end
      run("beq_not_taken", 32'h11090003, 1'b0, 1, 0);
      n_tests++;
      if (obs_pc_ld !== 0) begin
         n_fail++;
         $display("FAIL beq_not_taken_pc_ld got %0d expected 0", obs_pc_ld);
      end
      run("bne_taken", 32'h15090003, 1'b0, 0, 0);
   endtask

   task automatic test_mult();
      run("mult", 32'h01090018, 1'b0, 2, 0);
      n_tests++;
      if (obs_hilo !== 1 || obs_d_en !== 0) begin
         n_fail++;
         $display("FAIL mult_strobes hilo=%0d d_en=%0d expected 1 0", obs_hilo, obs_d_en);
      end
      run("mfhi", 32'h00006010, 1'b0, 0, 0);
      run("mflo", 32'h00007012, 1'b0, 0, 0);
   endtask

   task automatic test_reset_mid_sw();
      cur_ir = 32'hAD0B0008; cur_z = 1'b0;
      build(cur_ir, 1'b0, 0, 10, 0);
      play("sw_before_reset", 5);   // fetch, decode, exec, two waiting MEM cycles
      q.delete();
      n_tests++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b1) begin
         n_fail++;
         $display("FAIL sw_in_mem mem_req=%b mem_wr=%b expected 1 1", mem_req, mem_wr);
      end
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1;
      @(negedge clk); #1;
      n_tests++;
      if (got !== idle()) begin
         n_fail++;
         $display("FAIL sw_reset_abandon got %h expected %h", got, idle());
      end
      reset = 1'b0; mem_ready = 1'b0;
      @(negedge clk); #1;
      n_tests++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b0 || D_En !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_reset_refetch mem_req=%b mem_wr=%b D_En=%b expected 1 0 0", mem_req, mem_wr, D_En);
      end
   endtask

   task automatic test_halt();
      cur_ir = 32'hFC000000; cur_z = 1'b0;
      build(cur_ir, 1'b0, 0, 0, 6);
      play("halt", 1000);
      pulse_reset("halt_exit");
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] alu_fns [6] = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A};
      logic [4:0]  rs  = 5'($urandom);
      logic [4:0]  rt  = 5'($urandom);
      logic [4:0]  rd  = 5'($urandom);
      logic [4:0]  sh  = 5'($urandom);
      logic [15:0] imm = 16'($urandom);
      logic [5:0]  fn, op;
      case ($urandom_range(0, 10))
         0: return {6'h00, rs, rt, rd, sh, alu_fns[$urandom_range(0, 5)]};
         1: return {6'h00, rs, rt, rd, sh, 6'h18};
         2: return {6'h00, rs, rt, rd, sh, 6'h10};
         3: return {6'h00, rs, rt, rd, sh, 6'h12};
         4: return {6'h08, rs, rt, imm};
         5: return {6'h23, rs, rt, imm};
         6: return {6'h2B, rs, rt, imm};
         7: return {6'h04, rs, rt, imm};
         8: return {6'h05, rs, rt, imm};
         9: begin
            do fn = 6'($urandom);
            while (fn inside {6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h10, 6'h12});
            return {6'h00, rs, rt, rd, sh, fn};
         end
         default: begin
            do op = 6'($urandom);
            while (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F});
            return {op, rs, rt, imm};
         end
      endcase
   endfunction

   task automatic test_random();
      for (int i = 0; i < 150; i++)
         run("random", rand_instr(), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3));
   endtask

   task automatic test_back_to_back();
      run("b2b_addi_r0", 32'h20000005, 1'b0, 0, 0);
      run("b2b_sw", 32'hAC0A0010, 1'b0, 0, 0);
      run("b2b_lw_r0", 32'h8C000000, 1'b0, 0, 0);
      run("b2b_nop", 32'hFFFF0000 & 32'h7FFFFFFF, 1'b1, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_lw_delay();
      test_branch();
      test_mult();
      test_back_to_back();
      test_reset_mid_sw();
      test_random();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
